// File: rtl/dmem_bridge.sv
// dmem_bridge: load/store bridge from the single-cycle core datapath to a
// valid/ready data-memory bus. It registers one request per memory
// instruction, issues it on the bus, waits for the response and returns the
// read word. The core is stalled until the access reaches DONE.
// Optional feature macro: DMEM_TIMEOUT_EN. When it is defined, an access that
// stays in REQ/RESP for TIMEOUT_CYCLES cycles is aborted with core_err=1.
module dmem_bridge #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   input  logic [3:0]        core_be,
   output logic [31:0]       core_rdata,
   output logic              core_err,
   output logic              stall,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_rerr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // timeout: the access has been outstanding long enough to be abandoned
   logic timeout;
   // completion: the current cycle finishes the pending bus phase
   logic completion;
   // abort: timeout takes effect only when nothing completes this cycle
   logic abort;

`ifdef DMEM_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] to_cnt;

   // Cycle counter: zero on REQ entry (it is held at zero in IDLE), counts REQ/RESP cycles
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         to_cnt <= '0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if (state == REQ || state == RESP) begin
         to_cnt <= to_cnt + 16'd1;
      end
   end

   // The >= keeps the abort armed in RESP after a handshake that landed on the last REQ cycle
   assign timeout = (state == REQ || state == RESP) && (to_cnt >= TIMEOUT_LAST);
`else
   // The timeout threshold has no effect in this build; the bridge waits indefinitely
   logic [15:0] unused_timeout_cycles;
   assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
   assign timeout = 1'b0;
`endif

   assign completion = (state == REQ && bus_ready) || (state == RESP && bus_rvalid);
   assign abort      = timeout && !completion;

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the combinational handshake and stall outputs
   always_comb begin
      state_nxt = state;
      bus_valid = 1'b0;
      stall     = n_rst & core_req & (state != DONE);
      case (state)
         IDLE: begin
            if (core_req) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            bus_valid = 1'b1;
            if (bus_ready) begin
               state_nxt = RESP;
            end else if (abort) begin
               state_nxt = DONE;
            end
         end
         RESP: begin
            if (bus_rvalid || abort) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Always return to IDLE so the retiring instruction is never reissued
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture in IDLE and response capture in RESP (or on abort)
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_be     <= '0;
         core_rdata <= '0;
         core_err   <= 1'b0;
      end else begin
         if (state == IDLE && core_req) begin
            bus_we    <= core_we;
            bus_addr  <= core_addr;
            bus_wdata <= core_wdata;
            bus_be    <= core_be;
            core_err  <= 1'b0;
         end
         if (state == RESP && bus_rvalid) begin
            core_rdata <= bus_we ? 32'd0 : bus_rdata;
            core_err   <= bus_rerr;
         end else if (abort) begin
            core_rdata <= 32'd0;
            core_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed bench for dmem_bridge. Each access is described by
// its bus wait counts; the expected per-cycle outputs follow from the access
// timeline (request cycle, REQ window, response cycle, DONE cycle).
module tb_dmem_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        core_req;
   logic        core_we;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [3:0]  core_be;
   logic [31:0] core_rdata;
   logic        core_err;
   logic        stall;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_rerr;

   dmem_bridge #(
      .ADDR_W(32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .core_req(core_req),
      .core_we(core_we),
      .core_addr(core_addr),
      .core_wdata(core_wdata),
      .core_be(core_be),
      .core_rdata(core_rdata),
      .core_err(core_err),
      .stall(stall),
      .bus_valid(bus_valid),
      .bus_ready(bus_ready),
      .bus_we(bus_we),
      .bus_addr(bus_addr),
      .bus_wdata(bus_wdata),
      .bus_be(bus_be),
      .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata),
      .bus_rerr(bus_rerr)
   );

   always #5 clk = ~clk;

   // Model state: expected output values for the current cycle
   logic        m_we, m_err, e_stall, e_valid;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   logic        chk_en = 1'b0;

   // Literal expectations queued by the stimulus, checked by the compare process
   string       lit_nm[64];
   logic [31:0] lit_act[64];
   logic [31:0] lit_exp[64];
   int          lit_n = 0;
   int          lit_done = 0;

   // Counters owned by the compare process
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int cnt_stall = 0;
   int cnt_valid = 0;
   int hs_q[$];

   // Per-access totals measured by the stimulus from the counters above
   int last_stall, last_valid;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Compare process: model check every cycle, then any queued literal checks
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("stall", {31'd0, stall}, {31'd0, e_stall});
         chk("bus_valid", {31'd0, bus_valid}, {31'd0, e_valid});
         chk("bus_we", {31'd0, bus_we}, {31'd0, m_we});
         chk("bus_addr", bus_addr, m_addr);
         chk("bus_wdata", bus_wdata, m_wdata);
         chk("bus_be", {28'd0, bus_be}, {28'd0, m_be});
         chk("core_rdata", core_rdata, m_rdata);
         chk("core_err", {31'd0, core_err}, {31'd0, m_err});
      end
      if (stall) cnt_stall++;
      if (bus_valid) cnt_valid++;
      if (bus_valid && bus_ready) hs_q.push_back(cyc);
      while (lit_done < lit_n) begin
         chk(lit_nm[lit_done], lit_act[lit_done], lit_exp[lit_done]);
         lit_done++;
      end
   end

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      lit_nm[lit_n]  = nm;
      lit_act[lit_n] = act;
      lit_exp[lit_n] = exp;
      lit_n++;
   endtask

   task automatic lit_all_zero(input string tag);
      lit({tag, "_stall"}, {31'd0, stall}, 32'd0);
      lit({tag, "_bus_valid"}, {31'd0, bus_valid}, 32'd0);
      lit({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
      lit({tag, "_bus_addr"}, bus_addr, 32'd0);
      lit({tag, "_bus_wdata"}, bus_wdata, 32'd0);
      lit({tag, "_bus_be"}, {28'd0, bus_be}, 32'd0);
      lit({tag, "_core_rdata"}, core_rdata, 32'd0);
      lit({tag, "_core_err"}, {31'd0, core_err}, 32'd0);
   endtask

   // Core idle for n cycles; called at posedge+1
   task automatic idle(input int n);
      core_req   = 1'b0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rerr   = 1'b0;
      e_stall    = 1'b0;
      e_valid    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One access: rw wait cycles before bus_ready, vw wait cycles before bus_rvalid.
   // noise drives junk bus_rvalid during REQ; tmo means the bus never accepts.
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int rw, input int vw,
                            input logic [31:0] rd, input logic rerr, input bit noise,
                            input bit tmo);
      int d, rsp, st0, va0;
      rsp = 2 + rw + vw;
      d   = tmo ? 1 + TMO : 3 + rw + vw;
      st0 = cnt_stall;
      va0 = cnt_valid;
      core_req   = 1'b1;
      core_we    = we;
      core_addr  = addr;
      core_wdata = wdata;
      core_be    = be;
      for (int k = 0; k <= d; k++) begin
         bus_ready  = !tmo && (k == 1 + rw);
         bus_rvalid = (!tmo && k == rsp) || (noise && k >= 1 && k <= 1 + rw);
         bus_rdata  = (!tmo && k == rsp) ? rd : (32'hBAD0_0000 | 32'(k));
         bus_rerr   = (!tmo && k == rsp) ? rerr : noise;
         e_stall    = (k < d);
         e_valid    = (k >= 1) && (k <= (tmo ? TMO : 1 + rw));
         if (k == 1) begin
            m_we    = we;
            m_addr  = addr;
            m_wdata = wdata;
            m_be    = be;
            m_err   = 1'b0;
         end
         if (k == d) begin
            m_rdata = (we || tmo) ? 32'd0 : rd;
            m_err   = tmo ? 1'b1 : rerr;
         end
         @(posedge clk);
         #1;
      end
      last_stall = cnt_stall - st0;
      last_valid = cnt_valid - va0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      n_rst      = 1'b0;
      core_req   = 1'b0;
      core_we    = 1'b0;
      core_addr  = '0;
      core_wdata = '0;
      core_be    = '0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      bus_rerr   = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0; m_err = 1'b0;
      e_stall = 1'b0; e_valid = 1'b0;
      #3;
      lit_all_zero("reset");
      @(posedge clk);
      #1;
      n_rst  = 1'b1;
      chk_en = 1'b1;
      idle(2);

      // Load on a zero-wait bus
      do_access(1'b0, 32'h2000_0010, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      lit("load_stall_cycles", 32'(last_stall), 32'd3);
      lit("load_rdata", core_rdata, 32'hDEAD_BEEF);
      lit("load_err", {31'd0, core_err}, 32'd0);
      idle(2);

      // Store with bus_ready low for 4 cycles and junk rvalid during REQ
      do_access(1'b1, 32'h2000_0020, 32'h0000_AB00, 4'b0010, 4, 0, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
      lit("store_valid_cycles", 32'(last_valid), 32'd5);
      lit("store_stall_cycles", 32'(last_stall), 32'd7);
      lit("store_rdata", core_rdata, 32'd0);
      idle(1);

      // Error response, then a clean access clears core_err
      do_access(1'b0, 32'h2000_0030, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
      lit("err_load_err", {31'd0, core_err}, 32'd1);
      lit("err_load_stall_cycles", 32'(last_stall), 32'd6);
      do_access(1'b0, 32'h2000_0034, 32'h0, 4'hF, 0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0);
      lit("clean_after_err", {31'd0, core_err}, 32'd0);
      idle(1);

      // Reset pulsed while waiting in RESP
      chk_en     = 1'b0;
      core_req   = 1'b1;
      core_we    = 1'b0;
      core_addr  = 32'h2000_0040;
      core_wdata = 32'h0;
      core_be    = 4'hF;
      @(posedge clk);
      #1;
      bus_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_ready = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      lit_all_zero("rst_mid");
      @(posedge clk);
      #1;
      n_rst      = 1'b1;
      core_req   = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h55AA_55AA;
      @(posedge clk);
      #1;
      bus_rvalid = 1'b0;
      lit_all_zero("rst_late_rvalid");
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0; m_err = 1'b0;
      e_stall = 1'b0; e_valid = 1'b0;
      chk_en  = 1'b1;
      idle(1);
      do_access(1'b1, 32'h2000_0044, 32'h1122_3344, 4'hF, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0);
      lit("after_rst_stall_cycles", 32'(last_stall), 32'd4);
      idle(1);

      // Two back-to-back loads
      hs0 = hs_q.size();
      do_access(1'b0, 32'h2000_0050, 32'h0, 4'hF, 0, 0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
      do_access(1'b0, 32'h2000_0054, 32'h0, 4'hF, 0, 0, 32'hA5A5_0002, 1'b0, 1'b0, 1'b0);
      idle(2);
      lit("b2b_handshakes", 32'(hs_q.size() - hs0), 32'd2);
      if (hs_q.size() - hs0 >= 2) begin
         lit("b2b_spacing", 32'(hs_q[hs0 + 1] - hs_q[hs0]), 32'd4);
      end
      lit("b2b_rdata", core_rdata, 32'hA5A5_0002);

`ifdef DMEM_TIMEOUT_EN
      // bus_ready stuck low: aborted after TMO cycles in REQ
      do_access(1'b0, 32'h2000_0060, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
      lit("tmo_err", {31'd0, core_err}, 32'd1);
      lit("tmo_rdata", core_rdata, 32'd0);
      lit("tmo_valid_cycles", 32'(last_valid), 32'd8);
      lit("tmo_stall_cycles", 32'(last_stall), 32'd9);
      idle(3);
`endif

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
